// File: rtl/conv_enc_pkg.sv
// Shared constants and types for the rate-1/2 K=7 convolutional encoder.
// Holds the default generator polynomials, shift-state width and FSM encoding.
package conv_enc_pkg;

    localparam int          K      = 7;
    localparam int          SW     = K - 1;
    localparam logic [6:0]  G1_DEF = 7'o171;
    localparam logic [6:0]  G2_DEF = 7'o133;

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_TAIL = 1'b1
    } state_t;

endpackage

// File: rtl/conv_enc.sv
// Rate-1/2 convolutional encoder (K=7, G1=171o, G2=133o) with one zero tail
// word appended per burst so the trellis ends in state 0.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_bits/valid/last  : w-bit word, in_bits[0] earliest in time
//   in_ready            : low only during the tail cycle
//   out_bits/valid/last : 2w coded bits {Y,X} per input bit, 1 cycle latency
module conv_enc
    import conv_enc_pkg::*;
#(
    parameter int         w  = 8,
    parameter logic [6:0] G1 = G1_DEF,
    parameter logic [6:0] G2 = G2_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [w-1:0]   in_bits,
    input  logic           in_valid,
    input  logic           in_last,
    output logic           in_ready,
    output logic [2*w-1:0] out_bits,
    output logic           out_valid,
    output logic           out_last
);

    // Encodes a whole word; returns {next_state, coded}.
    // Tap window bit (6-d) holds the bit at delay d, matching the
    // usual MSB-first reading of the octal generators.
    function automatic logic [2*w+SW-1:0] conv_word(
        input logic [SW-1:0] st,
        input logic [w-1:0]  bits
    );
        logic [SW-1:0]  s;
        logic [K-1:0]   win;
        logic [2*w-1:0] c;
        s = st;
        c = '0;
        for (int k = 0; k < w; k++) begin
            win        = {bits[k], s[0], s[1], s[2], s[3], s[4], s[5]};
            c[2*k]     = ^(win & G1);
            c[2*k+1]   = ^(win & G2);
            s          = {s[SW-2:0], bits[k]};
        end
        return {s, c};
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [SW-1:0]    r_s;
    logic [2*w-1:0]   r_out;
    logic             r_ov;
    logic             r_ol;

    logic             w_fire;
    logic             w_tail;
    logic [w-1:0]     w_enc_in;
    logic [2*w+SW-1:0] w_conv;

    always_comb begin
        w_next_state = r_state;
        w_fire       = 1'b0;
        w_tail       = 1'b0;
        w_enc_in     = in_bits;
        unique case (r_state)
            ST_DATA: begin
                if (in_valid) begin
                    w_fire = 1'b1;
                    if (in_last) begin
                        w_next_state = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                // Internal zero word flushes all six delay cells.
                w_fire       = 1'b1;
                w_tail       = 1'b1;
                w_enc_in     = '0;
                w_next_state = ST_DATA;
            end
            default: begin
                w_next_state = ST_DATA;
            end
        endcase
    end

    assign w_conv = conv_word(r_s, w_enc_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_DATA;
            r_s     <= '0;
            r_out   <= '0;
            r_ov    <= 1'b0;
            r_ol    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ov    <= w_fire;
            r_ol    <= w_tail;
            if (w_fire) begin
                r_s   <= w_conv[2*w+SW-1:2*w];
                r_out <= w_conv[2*w-1:0];
            end
        end
    end

    assign in_ready  = (r_state == ST_DATA);
    assign out_bits  = r_out;
    assign out_valid = r_ov;
    assign out_last  = r_ol;

endmodule
